// File: rtl/bp_update.sv
// bp_fifo: small generic FIFO with registered storage and a combinational head read.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: the caller gates push/pop; full/empty are decoded from the occupancy counter.
module bp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdat,
  input  logic             pop,
  output logic [WIDTH-1:0] rdat,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign rdat  = mem[rptr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdat;
  end
endmodule

// bp_update: queues resolved branches and read-modify-writes the 2-bit table entry (stats: BP_UPD_STATS_EN).
// Latency: tbl_rd earliest 1 cycle after the push, tbl_we 3 cycles after; one update per 3 cycles.
// Backpressure: tbl_busy stalls READ/WRITE one cycle each; a push into a full FIFO drops unless a pop coincides.
module bp_update #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  res_valid,
  input  logic [31:0]           res_pc,
  input  logic                  res_taken,
  input  logic [31:0]           res_target,
  input  logic                  res_mispred,
  output logic                  upd_full,
  output logic                  upd_idle,
  input  logic                  tbl_busy,
  output logic                  tbl_rd,
  output logic [IDX_W-1:0]      tbl_addr,
  input  logic [1:0]            tbl_rcnt,
  input  logic [31-IDX_W-2:0]   tbl_rtag,
  output logic                  tbl_we,
  output logic [1:0]            tbl_wcnt,
  output logic [31-IDX_W-2:0]   tbl_wtag,
  output logic [31:0]           tbl_wtarget,
  output logic [15:0]           stat_mispred,
  output logic [15:0]           stat_drop
);
  typedef struct packed {
    logic [29:0] pc_w;
    logic        taken;
    logic [31:0] target;
  } hdr_t;

  typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;

  state_t     state, state_nxt;
  hdr_t       head, wrk;
  logic       fifo_empty, push, pop, hit;
  logic [1:0] wcnt_q, wcnt_nxt;
  logic       unused_pc_lo;

  assign unused_pc_lo = ^res_pc[1:0];

  assign pop  = (state == READ) && !tbl_busy;
  assign push = res_valid && (!upd_full || pop);

  bp_fifo #(.WIDTH($bits(hdr_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdat  ({res_pc[31:2], res_taken, res_target}),
    .pop   (pop),
    .rdat  (head),
    .full  (upd_full),
    .empty (fifo_empty)
  );

  assign upd_idle    = fifo_empty && (state == IDLE);
  assign tbl_rd      = pop;
  assign tbl_we      = (state == WRITE) && !tbl_busy;
  assign tbl_addr    = (state == READ) ? head.pc_w[IDX_W-1:0] : wrk.pc_w[IDX_W-1:0];
  assign tbl_wcnt    = wcnt_q;
  assign tbl_wtag    = wrk.pc_w[29:IDX_W];
  assign tbl_wtarget = wrk.target;

  assign hit = (tbl_rtag == wrk.pc_w[29:IDX_W]);

  // Saturating update; a miss only allocates (weak taken) when the branch was taken.
  always_comb begin
    wcnt_nxt = 2'b10;
    if (hit) begin
      if (wrk.taken) wcnt_nxt = (tbl_rcnt == 2'b11) ? 2'b11 : tbl_rcnt + 2'b01;
      else           wcnt_nxt = (tbl_rcnt == 2'b00) ? 2'b00 : tbl_rcnt - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wrk    <= '0;
      wcnt_q <= 2'b00;
    end else begin
      state <= state_nxt;
      if (pop)            wrk    <= head;
      if (state == CALC)  wcnt_q <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = READ;
      READ:    if (!tbl_busy) state_nxt = CALC;
      CALC:    state_nxt = (hit || wrk.taken) ? WRITE : IDLE;
      WRITE:   if (!tbl_busy) state_nxt = fifo_empty ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BP_UPD_STATS_EN
  logic [15:0] mis_q, drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q  <= 16'h0000;
      drop_q <= 16'h0000;
    end else begin
      if (push && res_mispred && (mis_q != 16'hFFFF))   mis_q  <= mis_q + 16'h0001;
      if (res_valid && !push && (drop_q != 16'hFFFF))   drop_q <= drop_q + 16'h0001;
    end
  end

  assign stat_mispred = mis_q;
  assign stat_drop    = drop_q;
`else
  logic unused_mispred;

  assign unused_mispred = res_mispred;
  assign stat_mispred   = 16'h0000;
  assign stat_drop      = 16'h0000;
`endif
endmodule

// File: tb/tb_bp_update.sv
// Bench for bp_update: owns the branch table, models the update queue and counter rules,
// and checks every cycle plus directed timing/value expectations.
module tb_bp_update;
  localparam int IDX_W = 4;
  localparam int DEPTH = 4;
  localparam int TAG_W = 32 - IDX_W - 2;
`ifdef BP_UPD_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             res_valid = 1'b0;
  logic [31:0]      res_pc = '0;
  logic             res_taken = 1'b0;
  logic [31:0]      res_target = '0;
  logic             res_mispred = 1'b0;
  logic             tbl_busy = 1'b0;
  logic [1:0]       tbl_rcnt;
  logic [TAG_W-1:0] tbl_rtag;
  logic             upd_full, upd_idle, tbl_rd, tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wcnt;
  logic [TAG_W-1:0] tbl_wtag;
  logic [31:0]      tbl_wtarget;
  logic [15:0]      stat_mispred, stat_drop;

  bp_update #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_mispred(res_mispred),
    .upd_full(upd_full), .upd_idle(upd_idle),
    .tbl_busy(tbl_busy), .tbl_rd(tbl_rd), .tbl_addr(tbl_addr),
    .tbl_rcnt(tbl_rcnt), .tbl_rtag(tbl_rtag),
    .tbl_we(tbl_we), .tbl_wcnt(tbl_wcnt), .tbl_wtag(tbl_wtag), .tbl_wtarget(tbl_wtarget),
    .stat_mispred(stat_mispred), .stat_drop(stat_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Branch table contents as seen by the table side; written only by accepted tbl_we.
  logic [1:0]       mem_cnt [16] = '{default: '0};
  logic [TAG_W-1:0] mem_tag [16] = '{default: '0};

  upd_t        mq[$];
  upd_t        cur;
  int          ph = 0;
  bit          exp_wr = 0;
  int          exp_cnt = 0;
  int          m_mis = 0;
  int          m_drop = 0;
  bit          rsp_pend = 0;
  logic [1:0]       rsp_cnt = '0;
  logic [TAG_W-1:0] rsp_tag = '0;

  int               we_cnt = 0;
  int               last_rd_cyc = -1;
  int               last_we_cyc = -1;
  logic [IDX_W-1:0] last_rd_addr = '0;
  logic [1:0]       last_we_cnt = '0;
  logic [TAG_W-1:0] last_we_tag = '0;
  logic [31:0]      last_we_tgt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Table read data is only valid the cycle after an accepted read; garbage otherwise.
  always @(posedge clk) begin
    #1;
    if (rsp_pend) begin
      tbl_rcnt = rsp_cnt;
      tbl_rtag = rsp_tag;
    end else begin
      tbl_rcnt = 2'($urandom());
      tbl_rtag = TAG_W'($urandom());
    end
  end

  always @(negedge clk) begin
    int               pre;
    int               c;
    bit               popped;
    bit               acc;
    bit               hit;
    logic [IDX_W-1:0] ix;
    logic [TAG_W-1:0] tg;
    upd_t             nu;
    if (!rst_n) begin
      chk("rst_tbl_rd", tbl_rd, 0);
      chk("rst_tbl_we", tbl_we, 0);
      chk("rst_tbl_addr", tbl_addr, 0);
      chk("rst_tbl_wcnt", tbl_wcnt, 0);
      chk("rst_tbl_wtag", tbl_wtag, 0);
      chk("rst_tbl_wtarget", tbl_wtarget, 0);
      chk("rst_upd_full", upd_full, 0);
      chk("rst_upd_idle", upd_idle, 1);
      chk("rst_stat_mispred", stat_mispred, 0);
      chk("rst_stat_drop", stat_drop, 0);
      mq.delete();
      ph = 0;
      rsp_pend = 0;
      m_mis = 0;
      m_drop = 0;
    end else begin
      pre = mq.size();
      popped = 0;
      chk("upd_full", upd_full, (pre == DEPTH) ? 1 : 0);
      chk("upd_idle", upd_idle, (pre == 0 && ph == 0) ? 1 : 0);
      chk("stat_mispred", stat_mispred, STATS * m_mis);
      chk("stat_drop", stat_drop, STATS * m_drop);
      chk("rd_when_busy", tbl_rd & tbl_busy, 0);
      if (pre == 0) chk("rd_when_empty", tbl_rd, 0);
      case (ph)
        1: begin
          chk("rd_in_calc", tbl_rd, 0);
          chk("we_in_calc", tbl_we, 0);
          rsp_pend = 0;
          ph = exp_wr ? 2 : 0;
        end
        2: begin
          chk("rd_in_write", tbl_rd, 0);
          chk("we_vs_busy", tbl_we, !tbl_busy);
          if (tbl_we) begin
            ix = cur.pc[IDX_W+1:2];
            tg = cur.pc[31:IDX_W+2];
            chk("we_addr", tbl_addr, ix);
            chk("we_cnt", tbl_wcnt, exp_cnt);
            chk("we_tag", tbl_wtag, tg);
            chk("we_target", tbl_wtarget, cur.target);
            mem_cnt[tbl_addr] = tbl_wcnt;
            mem_tag[tbl_addr] = tbl_wtag;
            we_cnt++;
            last_we_cyc = cyc;
            last_we_cnt = tbl_wcnt;
            last_we_tag = tbl_wtag;
            last_we_tgt = tbl_wtarget;
            ph = 0;
          end
        end
        default: begin
          chk("we_unexpected", tbl_we, 0);
          if (tbl_rd && !tbl_busy && pre > 0) begin
            cur = mq.pop_front();
            popped = 1;
            ix = cur.pc[IDX_W+1:2];
            tg = cur.pc[31:IDX_W+2];
            chk("rd_addr", tbl_addr, ix);
            c = int'(mem_cnt[ix]);
            hit = (mem_tag[ix] == tg);
            exp_wr = hit || cur.taken;
            if (!hit)           exp_cnt = 2;
            else if (cur.taken) exp_cnt = (c == 3) ? 3 : c + 1;
            else                exp_cnt = (c == 0) ? 0 : c - 1;
            rsp_cnt = mem_cnt[ix];
            rsp_tag = mem_tag[ix];
            rsp_pend = 1;
            last_rd_cyc = cyc;
            last_rd_addr = tbl_addr;
            ph = 1;
          end
        end
      endcase
      acc = res_valid && (pre < DEPTH || popped);
      if (acc) begin
        nu.pc = res_pc;
        nu.taken = res_taken;
        nu.target = res_target;
        mq.push_back(nu);
        if (res_mispred && m_mis < 65535) m_mis++;
      end else if (res_valid && m_drop < 65535) begin
        m_drop++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic mis);
    res_valid = 1'b1;
    res_pc = pc;
    res_taken = t;
    res_target = tgt;
    res_mispred = mis;
    step(1);
  endtask

  initial begin
    int n0;
    int w0;
    step(2);
    chk("reset_idle", upd_idle, 1);
    chk("reset_addr", tbl_addr, 0);
    rst_n = 1'b1;
    step(2);

    // Single taken miss at pc 0x40: allocate weak-taken.
    w0 = we_cnt;
    drive(32'h0000_0040, 1'b1, 32'h0000_1234, 1'b1);
    n0 = cyc;
    res_valid = 1'b0;
    step(6);
    chk("t1_rd_cyc", last_rd_cyc, n0 + 1);
    chk("t1_rd_addr", last_rd_addr, 0);
    chk("t1_we_cyc", last_we_cyc, n0 + 3);
    chk("t1_wcnt", last_we_cnt, 2);
    chk("t1_wtag", last_we_tag, 1);
    chk("t1_wtarget", last_we_tgt, 32'h0000_1234);
    chk("t1_writes", we_cnt - w0, 1);

    // Three taken updates to one entry back to back: 2, 3, then saturate at 3.
    w0 = we_cnt;
    drive(32'h0000_1008, 1'b1, 32'h0000_00A0, 1'b0);
    n0 = cyc;
    drive(32'h0000_1008, 1'b1, 32'h0000_00A0, 1'b0);
    drive(32'h0000_1008, 1'b1, 32'h0000_00A0, 1'b0);
    res_valid = 1'b0;
    step(12);
    chk("t2_wcnt_sat_hi", last_we_cnt, 3);
    chk("t2_we_cyc", last_we_cyc, n0 + 9);
    chk("t2_writes", we_cnt - w0, 3);

    // Allocate then three not-taken: 2, 1, 0, then saturate at 0.
    w0 = we_cnt;
    drive(32'h0000_2014, 1'b1, 32'h0000_00B0, 1'b0);
    n0 = cyc;
    drive(32'h0000_2014, 1'b0, 32'h0000_00B0, 1'b0);
    drive(32'h0000_2014, 1'b0, 32'h0000_00B0, 1'b0);
    drive(32'h0000_2014, 1'b0, 32'h0000_00B0, 1'b0);
    res_valid = 1'b0;
    step(14);
    chk("t3_wcnt_sat_lo", last_we_cnt, 0);
    chk("t3_we_cyc", last_we_cyc, n0 + 12);
    chk("t3_writes", we_cnt - w0, 4);

    // Not-taken miss: no write and idle again three cycles after the push.
    w0 = we_cnt;
    drive(32'h0000_3018, 1'b0, 32'h0000_00C0, 1'b0);
    n0 = cyc;
    res_valid = 1'b0;
    step(2);
    chk("t4_busy_in_calc", upd_idle, 0);
    step(1);
    chk("t4_idle_n3", upd_idle, 1);
    step(3);
    chk("t4_rd_cyc", last_rd_cyc, n0 + 1);
    chk("t4_writes", we_cnt - w0, 0);

    // Table busy: four pushes fill the FIFO, the fifth is dropped.
    w0 = we_cnt;
    tbl_busy = 1'b1;
    drive(32'h0000_0100, 1'b1, 32'h0000_0D00, 1'b0);
    drive(32'h0000_0100, 1'b1, 32'h0000_0D01, 1'b0);
    drive(32'h0000_0108, 1'b1, 32'h0000_0D02, 1'b0);
    drive(32'h0000_0100, 1'b0, 32'h0000_0D03, 1'b0);
    chk("t5_full_after_4", upd_full, 1);
    drive(32'h0000_010C, 1'b1, 32'h0000_0D04, 1'b1);
    res_valid = 1'b0;
    step(1);
    chk("t5_stat_drop", stat_drop, STATS * 1);
    chk("t5_stat_mispred", stat_mispred, STATS * 1);
    tbl_busy = 1'b0;
    step(20);
    chk("t5_writes", we_cnt - w0, 4);
    chk("t5_last_tag", last_we_tag, 4);
    chk("t5_last_cnt", last_we_cnt, 2);
    chk("t5_idx0_cnt", mem_cnt[0], 2);

    // Full FIFO with a coinciding pop: the fifth push is accepted.
    w0 = we_cnt;
    tbl_busy = 1'b1;
    drive(32'h0000_0300, 1'b1, 32'h0000_0E00, 1'b0);
    drive(32'h0000_0304, 1'b1, 32'h0000_0E01, 1'b0);
    drive(32'h0000_0308, 1'b1, 32'h0000_0E02, 1'b0);
    drive(32'h0000_030C, 1'b1, 32'h0000_0E03, 1'b0);
    tbl_busy = 1'b0;
    drive(32'h0000_0310, 1'b1, 32'h0000_0E04, 1'b1);
    res_valid = 1'b0;
    chk("t6_full_push_pop", upd_full, 1);
    step(1);
    chk("t6_stat_drop", stat_drop, STATS * 1);
    chk("t6_stat_mispred", stat_mispred, STATS * 2);
    step(20);
    chk("t6_writes", we_cnt - w0, 5);
    chk("t6_last_tag", last_we_tag, 32'hC);
    chk("t6_last_target", last_we_tgt, 32'h0000_0E04);

    // Busy two cycles in READ and one in WRITE: write lands at N+6.
    drive(32'h0000_0050, 1'b1, 32'h0000_BEEF, 1'b0);
    n0 = cyc;
    res_valid = 1'b0;
    tbl_busy = 1'b1;
    step(3);
    tbl_busy = 1'b0;
    step(2);
    tbl_busy = 1'b1;
    step(1);
    tbl_busy = 1'b0;
    step(4);
    chk("t7_rd_cyc", last_rd_cyc, n0 + 3);
    chk("t7_we_cyc", last_we_cyc, n0 + 6);
    chk("t7_wcnt", last_we_cnt, 2);
    chk("t7_wtag", last_we_tag, 1);
    chk("t7_wtarget", last_we_tgt, 32'h0000_BEEF);

    // Reset during CALC with two entries queued.
    w0 = we_cnt;
    drive(32'h0000_0400, 1'b1, 32'h0000_0F00, 1'b1);
    drive(32'h0000_0404, 1'b1, 32'h0000_0F01, 1'b0);
    drive(32'h0000_0408, 1'b1, 32'h0000_0F02, 1'b0);
    res_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t8_idle_in_reset", upd_idle, 1);
    chk("t8_full_in_reset", upd_full, 0);
    chk("t8_we_in_reset", tbl_we, 0);
    step(1);
    rst_n = 1'b1;
    step(10);
    chk("t8_writes", we_cnt - w0, 0);
    chk("t8_idle_after", upd_idle, 1);
    chk("t8_stat_mispred", stat_mispred, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
